// File: rtl/perceptron_trainer.sv
// Training sequencer for the perceptron core: loads labelled samples, replays them
// per epoch and counts mismatches. Optional run-wide error counter: PERCEPTRON_TRAINER_ERR_TOTAL_EN.
module perceptron_trainer #(
  parameter int N_SAMPLES  = 8,
  parameter int MAX_EPOCHS = 15,
  parameter int SETTLE     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  output logic        load_ready,
  input  logic [7:0]  threshold_cfg,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        converged,
  output logic [3:0]  epoch,
  output logic [3:0]  errors,
  output logic [15:0] err_total,
  output logic [6:0]  p_in,
  output logic [7:0]  p_threshold,
  output logic        p_exp_res,
  input  logic [1:0]  p_result
);
  localparam int AW = $clog2(N_SAMPLES);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(SETTLE);

  typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, EPOCH_END} state_t;

  state_t        state;
  logic [7:0]    mem [N_SAMPLES];
  logic [AW-1:0] wr_ptr, rd_idx;
  logic [CW-1:0] count;
  logic [SW-1:0] settle;
  logic          accept, start_ok, mismatch, last_sample;

  assign load_ready  = (state == IDLE) && !start;
  assign accept      = load_valid && load_ready;
  assign start_ok    = (state == IDLE) && start && (count != '0);
  assign mismatch    = p_result != (p_exp_res ? 2'b01 : 2'b11);
  assign last_sample = {1'b0, rd_idx} == (count - CW'(1));

  // Sample storage survives reset; only the pointer and count are cleared.
  always_ff @(posedge clk)
    if (accept) mem[wr_ptr] <= load_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      converged   <= 1'b0;
      epoch       <= '0;
      errors      <= '0;
      p_in        <= '0;
      p_threshold <= '0;
      p_exp_res   <= 1'b0;
      wr_ptr      <= '0;
      count       <= '0;
      rd_idx      <= '0;
      settle      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (count != CW'(N_SAMPLES)) count <= count + CW'(1);
          end
          if (start_ok) begin
            p_threshold <= threshold_cfg;
            done        <= 1'b0;
            converged   <= 1'b0;
            epoch       <= '0;
            errors      <= '0;
            busy        <= 1'b1;
            rd_idx      <= '0;
            state       <= APPLY;
          end
        end
        APPLY: begin
          p_in      <= mem[rd_idx][6:0];
          p_exp_res <= mem[rd_idx][7];
          settle    <= SW'(SETTLE - 1);
          state     <= WAIT;
        end
        WAIT: begin
          if (settle == '0) state <= CHECK;
          else              settle <= settle - SW'(1);
        end
        CHECK: begin
          if (mismatch && errors != 4'hF) errors <= errors + 4'd1;
          if (last_sample) state <= EPOCH_END;
          else begin
            rd_idx <= rd_idx + AW'(1);
            state  <= APPLY;
          end
        end
        EPOCH_END: begin
          if (errors == '0 || epoch == 4'(MAX_EPOCHS - 1)) begin
            converged <= (errors == '0);
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            epoch  <= epoch + 4'd1;
            errors <= '0;
            rd_idx <= '0;
            state  <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PERCEPTRON_TRAINER_ERR_TOTAL_EN
  logic [15:0] err_cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                           err_cnt <= '0;
    else if (start_ok)                                    err_cnt <= '0;
    else if (state == CHECK && mismatch && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
  end
  assign err_total = err_cnt;
`else
  assign err_total = 16'd0;
`endif

endmodule

// File: tb/tb_perceptron_trainer.sv
// Randomized scoreboard bench for perceptron_trainer: a behavioural core model answers
// p_in, a reference model predicts per-sample traffic and run outcomes, a monitor checks them.
module tb_perceptron_trainer;
  localparam int N = 8, MAXE = 2, S = 3;

  logic        clk = 0, reset = 0;
  logic        load_valid = 0, load_ready, start = 0;
  logic [7:0]  load_data = 0, threshold_cfg = 0;
  logic        busy, done, converged, p_exp_res;
  logic [3:0]  epoch, errors;
  logic [15:0] err_total;
  logic [6:0]  p_in;
  logic [7:0]  p_threshold;
  logic [1:0]  p_result;

  perceptron_trainer #(.N_SAMPLES(N), .MAX_EPOCHS(MAXE), .SETTLE(S)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .threshold_cfg(threshold_cfg), .start(start), .busy(busy),
    .done(done), .converged(converged), .epoch(epoch), .errors(errors),
    .err_total(err_total), .p_in(p_in), .p_threshold(p_threshold),
    .p_exp_res(p_exp_res), .p_result(p_result));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  function automatic void chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Core model: 0 always right, 1 always +1, 2 invalid 00, 3 wrong on odd inputs,
  // 4 invalid 10 until the trainer reaches epoch learn_ep.
  int mode = 0, learn_ep = 0;
  always_comb begin
    logic [1:0] right, wrong;
    right = p_exp_res ? 2'b01 : 2'b11;
    wrong = p_exp_res ? 2'b11 : 2'b01;
    case (mode)
      0:       p_result = right;
      1:       p_result = 2'b01;
      2:       p_result = 2'b00;
      3:       p_result = p_in[0] ? wrong : right;
      default: p_result = (int'(epoch) < learn_ep) ? 2'b10 : right;
    endcase
  end

  function automatic bit mis(int md, int e, logic [7:0] s);
    case (md)
      0: return 1'b0;
      1: return s[7] == 1'b0;
      2: return 1'b1;
      3: return s[0];
      default: return e < learn_ep;
    endcase
  endfunction

  typedef struct { bit conv; int ep; int errs; int tot; int dur; logic [7:0] thr; } exp_t;
  exp_t            rq[$];
  logic [7:0]      sq[$];
  logic [7:0]      mem_m [N];
  int              wp_m = 0, cnt_m = 0, cur_cnt = 1;

  // Monitor: tracks position inside the run purely from busy-cycle offset.
  int bcnt = 0;
  bit was_busy = 0;
  logic [6:0] hold_in;
  always @(negedge clk) begin
    if (!reset) begin
      bcnt = 0; was_busy = 0;
    end else begin
      if (busy) begin
        int per, r, ph;
        per = cur_cnt * (S + 2) + 1;
        r = bcnt % per;
        if (r < cur_cnt * (S + 2)) begin
          ph = r % (S + 2);
          if (ph == 1) hold_in = p_in;
          else if (ph > 1) chk("p_in_stable", p_in, hold_in);
          if (ph == S + 1) begin
            if (sq.size() == 0) chk("sample_unexpected", 1, 0);
            else begin
              logic [7:0] s;
              s = sq.pop_front();
              chk("p_in", p_in, s[6:0]);
              chk("p_exp_res", p_exp_res, s[7]);
            end
          end
        end
        bcnt++;
      end else if (was_busy) begin
        if (rq.size() == 0) chk("result_unexpected", 1, 0);
        else begin
          exp_t x;
          x = rq.pop_front();
          chk("done", done, 1);
          chk("converged", converged, x.conv);
          chk("epoch", epoch, x.ep);
          chk("errors", errors, x.errs);
          chk("err_total", err_total, x.tot);
          chk("busy_cycles", bcnt, x.dur);
          chk("p_threshold", p_threshold, x.thr);
        end
        bcnt = 0;
      end
      was_busy = busy;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    #1 reset = 0;
    sq.delete(); rq.delete();
    wp_m = 0; cnt_m = 0;
    tick(); tick();
    reset = 1;
    tick();
  endtask

  task automatic load_beat(input logic [7:0] d);
    load_valid = 1; load_data = d;
    #1 chk("load_ready_idle", load_ready, 1);
    tick();
    load_valid = 0;
    mem_m[wp_m] = d;
    wp_m = (wp_m + 1) % N;
    if (cnt_m < N) cnt_m++;
  endtask

  task automatic run(input int md, input bit lv_too, input bit poke);
    exp_t x;
    int errs, tot;
    bit ok;
    x.thr = 8'($urandom);
    tot = 0; errs = 0;
    for (int e = 0; e < MAXE; e++) begin
      errs = 0;
      for (int j = 0; j < cnt_m; j++) begin
        sq.push_back(mem_m[j]);
        if (mis(md, e, mem_m[j])) errs++;
      end
      tot += errs;
      x.ep = e;
      if (errs == 0) break;
    end
    x.conv = (errs == 0);
    x.errs = (errs > 15) ? 15 : errs;
`ifdef PERCEPTRON_TRAINER_ERR_TOTAL_EN
    x.tot = (tot > 65535) ? 65535 : tot;
`else
    x.tot = 0;
`endif
    x.dur = (x.ep + 1) * (cnt_m * (S + 2) + 1);
    rq.push_back(x);
    mode = md; threshold_cfg = x.thr; cur_cnt = cnt_m;
    start = 1;
    if (lv_too) begin load_valid = 1; load_data = 8'($urandom); end
    #1 chk("load_ready_start", load_ready, 0);
    tick();
    start = 0; load_valid = 0;
    if (poke) begin
      repeat (3) tick();
      start = 1;
      #1 chk("load_ready_busy", load_ready, 0);
      tick();
      start = 0;
    end
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (done && !busy) begin ok = 1; break; end
      tick();
    end
    if (!ok) chk("run_timeout", 0, 1);
    tick(); tick();
    chk("done_sticky", done, 1);
  endtask

  initial begin
    tick();
    reset = 1;
    tick();
    chk("rst_busy", busy, 0);        chk("rst_done", done, 0);
    chk("rst_converged", converged, 0);
    chk("rst_epoch", epoch, 0);      chk("rst_errors", errors, 0);
    chk("rst_p_in", p_in, 0);        chk("rst_p_thr", p_threshold, 0);
    chk("rst_p_exp", p_exp_res, 0);  chk("rst_err_total", err_total, 0);
    chk("rst_load_ready", load_ready, 1);

    // Start with an empty memory is ignored.
    start = 1; tick(); start = 0; tick();
    chk("start_empty_ignored", busy, 0);

    // Converging run, 4 samples.
    for (int i = 0; i < 4; i++) load_beat(8'($urandom));
    run(0, 0, 0);

    // Epoch exhaustion: every label -1, core always answers +1.
    do_reset();
    for (int i = 0; i < 3; i++) load_beat({1'b0, 7'($urandom)});
    run(1, 0, 0);

    // Invalid 2'b00 answers on +1 samples.
    do_reset();
    for (int i = 0; i < 2; i++) load_beat({1'b1, 7'($urandom)});
    run(2, 0, 0);

    // Load wrap with a colliding beat on start and a start pulse mid-run.
    do_reset();
    for (int i = 0; i < 10; i++) load_beat(8'($urandom));
    run(3, 1, 1);

    // Reset while in WAIT, then start must be ignored until a reload.
    mode = 0; cur_cnt = cnt_m;
    start = 1; tick(); start = 0;
    tick();
    reset = 0;
    sq.delete(); rq.delete(); wp_m = 0; cnt_m = 0;
    tick();
    chk("mid_busy", busy, 0);   chk("mid_done", done, 0);
    chk("mid_epoch", epoch, 0); chk("mid_errors", errors, 0);
    chk("mid_p_in", p_in, 0);   chk("mid_p_exp", p_exp_res, 0);
    chk("mid_p_thr", p_threshold, 0); chk("mid_err_total", err_total, 0);
    reset = 1; tick();
    start = 1; tick(); start = 0; tick();
    chk("start_after_reset_ignored", busy, 0);
    load_beat(8'($urandom));
    run(0, 0, 1);

    // Random runs.
    for (int k = 0; k < 10; k++) begin
      int nb;
      do_reset();
      nb = $urandom_range(1, 12);
      for (int i = 0; i < nb; i++) load_beat(8'($urandom));
      learn_ep = $urandom_range(0, 2);
      run($urandom_range(0, 4), $urandom_range(0, 1), $urandom_range(0, 1));
    end

    chk("sample_q_drained", sq.size(), 0);
    chk("result_q_drained", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/perceptron_trainer.md
# perceptron_trainer

Training sequencer for the `perceptron` core, driving its `in`, `threshold` and `exp_res` inputs and sampling its `result` output. Software or a test harness loads up to N_SAMPLES labelled samples. The block then replays them epoch by epoch. It counts mismatches per epoch and stops when an epoch is error-free or when the epoch budget runs out. It sits beside the perceptron core and owns the core's input side.

## Interface
Parameters:
- N_SAMPLES, 8: sample memory depth; power of two, 2..16.
- MAX_EPOCHS, 15: epoch budget, 1..15.
- SETTLE, 3: cycles a sample is held before `p_result` is sampled, ≥2.

Ports:
- clk  in  1  clock.
- reset  in  1  active-low reset, asynchronous assert.
- load_valid  in  1  sample beat valid.
- load_data  in  8  [7] = label (1 → +1, 0 → −1); [6:0] = input vector.
- load_ready  out  1  beat accepted when valid & ready.
- threshold_cfg  in  8  threshold captured at start.
- start  in  1  one-cycle pulse that begins a run.
- busy  out  1  run in progress.
- done  out  1  sticky; run finished.
- converged  out  1  last run ended with a zero-error epoch.
- epoch  out  4  current or final epoch index.
- errors  out  4  mismatches in the current or last epoch; saturates at 15.
- err_total  out  16  see Configuration.
- p_in  out  7  to perceptron `in`.
- p_threshold  out  8  to perceptron `threshold`.
- p_exp_res  out  1  to perceptron `exp_res`.
- p_result  in  2  from perceptron `result`: 2'b01 = +1, 2'b11 = −1.

## Operation
- States: IDLE, APPLY, WAIT, CHECK, EPOCH_END.
- **Reset values:**
  - State IDLE.
  - `busy`, `done`, `converged` = 0.
  - `epoch`, `errors` = 0.
  - `p_in` = 0, `p_threshold` = 0, `p_exp_res` = 0, `err_total` = 0.
  - Write pointer and sample count = 0.
  - Memory contents are not reset.
- **Loading:**
  - `load_ready` = (state == IDLE) & !start.
  - Each accepted beat writes mem[wr_ptr], and wr_ptr increments modulo N_SAMPLES. Beats past N_SAMPLES overwrite from index 0.
  - `count` saturates at N_SAMPLES.
- **Start:**
  - Accepted only in IDLE with count ≥ 1. Otherwise it is ignored, including while `busy`.
  - On acceptance: capture `threshold_cfg` into `p_threshold`, clear `done`/`converged`/`epoch`/`errors`, set `busy`, set rd_idx = 0, and go to APPLY.
  - start and load_valid in the same cycle: start wins and the beat is not accepted.
- **APPLY** (1 cycle):
  - Register `p_in` = mem[rd_idx][6:0] and `p_exp_res` = mem[rd_idx][7].
  - Load the settle counter with SETTLE−1, then go to WAIT.
- **WAIT:**
  - Decrement the settle counter each cycle and go to CHECK at 0.
  - `p_in` and `p_exp_res` are held stable.
- **CHECK** (1 cycle):
  - Mismatch if `p_result` ≠ (`p_exp_res` ? 2'b01 : 2'b11).
  - 2'b00 and 2'b10 always count as mismatch.
  - On mismatch, `errors` increments (saturating at 15).
  - If rd_idx == count−1, go to EPOCH_END. Otherwise rd_idx++ and go to APPLY.
- **EPOCH_END** (1 cycle), three cases:
  - `errors` == 0: `converged` = 1, `done` = 1, `busy` = 0, go to IDLE.
  - `errors` > 0 and `epoch` == MAX_EPOCHS−1: `converged` = 0, `done` = 1, `busy` = 0, go to IDLE.
  - Otherwise: `epoch`++, `errors` = 0, rd_idx = 0, go to APPLY.
- **Result holding:**
  - `epoch` and `errors` keep their final values after done.
  - `p_*` outputs hold their last values in IDLE.
- **Reset mid-run:** returns immediately to reset values. Sample memory is preserved, but count = 0, so samples must be reloaded before start is accepted.

## Timing
- Load: one beat per cycle while ready.
- Start to first `p_in` update: 2 cycles (start accepted at edge N, APPLY registers at edge N+1).
- Per sample: 1 + SETTLE + 1 cycles. `p_result` is sampled SETTLE+1 edges after `p_in` changes, which covers the core's 2-register latency.
- Per epoch: count·(SETTLE+2) + 1 cycles.
- `done` rises on the edge that leaves EPOCH_END, in the same cycle `busy` falls.

## Configuration
- Macro: `PERCEPTRON_TRAINER_ERR_TOTAL_EN`.
- Defined: `err_total` counts every CHECK mismatch across all epochs of the run. It clears on accepted start and saturates at 16'hFFFF.
- Undefined: `err_total` is tied to 0 and no counter is built. All other behaviour is identical.

## Test plan
- **Reset defaults:** assert reset mid-WAIT → all outputs read reset values next cycle; start is ignored until ≥1 sample is reloaded.
- **Load wrap:** load 10 beats with N_SAMPLES=8 → count = 8; mem[0], mem[1] hold beats 8 and 9; `load_ready` = 0 whenever start is high.
- **Converging run:** 4 samples; a model core returns the correct label every time → after 1 epoch `done` = 1, `converged` = 1, `epoch` = 0, `errors` = 0; total busy time = 4·5+1 = 21 cycles after APPLY entry (SETTLE=3).
- **Epoch exhaustion:** model core always returns 2'b01 while every label is 0, 3 samples, MAX_EPOCHS=2 → `done` = 1, `converged` = 0, `epoch` = 1, `errors` = 3; `err_total` = 6 with the macro defined, 0 without.
- **Invalid result:** core returns 2'b00 on a +1 sample → counted as a mismatch.
- **Start while busy:** pulse start during WAIT → ignored; run timing unchanged; `p_in` stable across all WAIT cycles.
